keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_debounce.sv | 108 ++++++++++
 rtl/keypad_scanner.sv | 115 +++++++++++
 tb/tb_keypad_scanner.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and the default 4x3 keymap for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    FrameNone   = 2'd0,
    FrameSingle = 2'd1,
    FrameMulti  = 2'd2
  } frame_kind_e;

  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  // idx = row_idx * 3 + col_idx; row 0 carries E/0/F, rows 1..3 carry 1..9.
  function automatic logic [3:0] keymap_4x3(input int unsigned idx);
    logic [3:0] code;
    code = 4'h0;
    case (idx)
      0:       code = KEY_E;
      1:       code = 4'h0;
      2:       code = KEY_F;
      3:       code = 4'h1;
      4:       code = 4'h2;
      5:       code = 4'h3;
      6:       code = 4'h4;
      7:       code = 4'h5;
      8:       code = 4'h6;
      9:       code = 4'h7;
      10:      code = 4'h8;
      11:      code = 4'h9;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-frame debounce: tracks a candidate frame result and publishes accepted keys.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned CODE_W   = 4,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned USE_MAP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_valid,
  input  frame_kind_e       frame_kind,
  input  logic [CODE_W-1:0] frame_idx,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              multi_key
);

  localparam logic [3:0] DebCnt = 4'(DEBOUNCE);

  frame_kind_e       cand_kind_q, cand_kind_d;
  logic [CODE_W-1:0] cand_idx_q, cand_idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              match, accept;
  logic [CODE_W-1:0] mapped;

  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;
  logic              multi_key_q, multi_key_d;

  assign mapped = (USE_MAP != 0) ? CODE_W'(keymap_4x3(32'(frame_idx))) : frame_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_kind_q <= FrameNone;
      cand_idx_q  <= '0;
      cnt_q       <= 4'd0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      cand_kind_q <= cand_kind_d;
      cand_idx_q  <= cand_idx_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_key_q <= multi_key_d;
    end
  end

  always_comb begin
    cand_kind_d = cand_kind_q;
    cand_idx_d  = cand_idx_q;
    cnt_d       = cnt_q;
    match       = 1'b0;
    accept      = 1'b0;
    if (frame_valid) begin
      match = (frame_kind == cand_kind_q) &&
              ((frame_kind != FrameSingle) || (frame_idx == cand_idx_q));
      if (match) begin
        if (cnt_q != 4'd15) cnt_d = cnt_q + 4'd1;
      end else begin
        cand_kind_d = frame_kind;
        cand_idx_d  = frame_idx;
        cnt_d       = 4'd1;
      end
      // Fire only on the frame that reaches the threshold, not while saturated there.
      accept = (cnt_d == DebCnt) && (!match || (cnt_q != DebCnt));
    end
  end

  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    multi_key_d = multi_key_q;
    if (accept) begin
      case (frame_kind)
        FrameSingle: begin
          if (!key_held_q || (key_code_q != mapped)) begin
            key_code_d  = mapped;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            multi_key_d = 1'b0;
          end
        end
        FrameMulti: begin
          multi_key_d = 1'b1;
          key_held_d  = 1'b0;
        end
        default: begin
          key_held_d  = 1'b0;
          multi_key_d = 1'b0;
        end
      endcase
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_key_q;

endmodule

// File: rtl/keypad_scanner.sv
// Row-strobing keypad scanner: synchronizes columns, rotates rows on a tick and
// collapses each full scan into a NONE/SINGLE/MULTI frame result for debounce.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 3,
  parameter int unsigned SCAN_DIV = 25000,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CODE_W   = 4,
  parameter int unsigned USE_MAP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   column,
  output logic [ROWS-1:0]   row,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              multi_key
);

  localparam int unsigned RowW = $clog2(ROWS);
  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned DivW = $clog2(SCAN_DIV);

  if ((ROWS < 2) || (COLS == 0) || (SCAN_DIV < 4) || (DEBOUNCE == 0) || (DEBOUNCE > 15) ||
      (CODE_W == 0) || ((64'(ROWS) * 64'(COLS)) > (64'd1 << CODE_W)) ||
      ((USE_MAP != 0) && ((ROWS != 4) || (COLS != 3)))) begin : g_param_check
    $fatal(1, "keypad_scanner: illegal parameter combination");
  end

  logic [COLS-1:0]   col_s1_q, col_s2_q;
  logic [DivW-1:0]   div_q, div_d;
  logic [RowW-1:0]   row_idx_q, row_idx_d;
  logic [1:0]        acc_cnt_q, acc_cnt_d;
  logic [CODE_W-1:0] acc_idx_q, acc_idx_d;

  logic              tick, last_row;
  logic [1:0]        row_cnt;
  logic [ColW-1:0]   first_col;
  logic [2:0]        cnt_sum;
  logic [1:0]        sum_cnt;
  logic [CODE_W-1:0] sum_idx;
  logic              frame_valid;
  frame_kind_e       frame_kind;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1_q  <= '0;
      col_s2_q  <= '0;
      div_q     <= '0;
      row_idx_q <= '0;
      acc_cnt_q <= 2'd0;
      acc_idx_q <= '0;
    end else begin
      col_s1_q  <= column;
      col_s2_q  <= col_s1_q;
      div_q     <= div_d;
      row_idx_q <= row_idx_d;
      acc_cnt_q <= acc_cnt_d;
      acc_idx_q <= acc_idx_d;
    end
  end

  assign tick     = (div_q == DivW'(SCAN_DIV - 1));
  assign last_row = (row_idx_q == RowW'(ROWS - 1));
  assign div_d    = tick ? '0 : div_q + DivW'(1);
  assign row_idx_d = !tick ? row_idx_q : (last_row ? '0 : row_idx_q + RowW'(1));
  assign row      = ROWS'(1) << row_idx_q;

  // Per-row key count (saturating at 2) and lowest asserted column.
  always_comb begin
    row_cnt   = 2'd0;
    first_col = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_s2_q[c]) begin
        if (row_cnt == 2'd0) first_col = ColW'(c);
        if (row_cnt != 2'd2) row_cnt = row_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    sum_cnt = acc_cnt_q;
    sum_idx = acc_idx_q;
    cnt_sum = {1'b0, acc_cnt_q} + {1'b0, row_cnt};
    if (tick && (row_cnt != 2'd0)) begin
      if (acc_cnt_q == 2'd0) sum_idx = CODE_W'(32'(row_idx_q) * COLS + 32'(first_col));
      sum_cnt = (cnt_sum >= 3'd2) ? 2'd2 : cnt_sum[1:0];
    end
    frame_valid = tick && last_row;
    acc_cnt_d   = frame_valid ? 2'd0 : sum_cnt;
    acc_idx_d   = frame_valid ? '0 : sum_idx;
    frame_kind  = (sum_cnt == 2'd0) ? FrameNone :
                  (sum_cnt == 2'd1) ? FrameSingle : FrameMulti;
  end

  keypad_debounce #(
    .CODE_W  (CODE_W),
    .DEBOUNCE(DEBOUNCE),
    .USE_MAP (USE_MAP)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .frame_valid(frame_valid),
    .frame_kind (frame_kind),
    .frame_idx  (sum_idx),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .multi_key  (multi_key)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3 (16-cycle frames).
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [2:0]  column;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        multi_key;
  logic [11:0] pressed;

  int passed = 0;
  int total = 0;
  int pulse_cnt = 0;
  int edge_n = -1;
  int exp_q[$];

  keypad_scanner #(
    .ROWS    (4),
    .COLS    (3),
    .SCAN_DIV(4),
    .DEBOUNCE(3),
    .CODE_W  (4),
    .USE_MAP (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .column   (column),
    .row      (row),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .multi_key(multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed key shorts its row strobe onto its column.
  always_comb begin
    column = 3'b000;
    for (int r = 0; r < 4; r++) begin
      if (row[r]) column = column | pressed[r*3 +: 3];
    end
  end

  // Edge index since reset release; frame ends land on edge_n % 16 == 15.
  always @(posedge clk) begin
    if (rst) edge_n <= -1;
    else edge_n <= edge_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic goto(input int k);
    while (edge_n < k) @(negedge clk);
  endtask

  function automatic logic [11:0] kb(input int idx);
    logic [11:0] one;
    one = 12'd1;
    return one << idx;
  endfunction

  // Scoreboard: every key_valid pulse consumes one expected code.
  always @(negedge clk) begin
    if (!rst && (key_valid === 1'b1)) begin
      int n;
      pulse_cnt++;
      n = exp_q.size();
      check("valid_phase", 32'(edge_n % 16), 32'd15);
      check("valid_expected", 32'(n > 0), 32'd1);
      if (n > 0) check("valid_code", 32'(key_code), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish by 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    pressed = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_row", 32'(row), 32'h1);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    check("rst_multi", 32'(multi_key), 32'h0);
    goto(2);  check("row_dwell", 32'(row), 32'h1);
    goto(3);  check("row_step1", 32'(row), 32'h2);
    goto(14); check("row_step3", 32'(row), 32'h8);
    goto(15); check("row_wrap", 32'(row), 32'h1);

    // Key 5 bouncing on alternate frames never reaches three matching frames.
    for (int f = 1; f <= 9; f++) begin
      goto(16 * f - 1);
      pressed = ((f <= 8) && (f % 2 == 1)) ? kb(7) : 12'd0;
    end
    goto(190);
    check("bounce_code", 32'(key_code), 32'h0);
    check("bounce_held", 32'(key_held), 32'h0);
    check("bounce_pulses", 32'(pulse_cnt), 32'd0);

    // Key 5 held for six frames: accepted at end of the third.
    goto(191); pressed = kb(7); exp_q.push_back(5);
    goto(238); check("k5_early", 32'(key_valid), 32'h0);
    goto(239);
    check("k5_valid", 32'(key_valid), 32'h1);
    check("k5_code", 32'(key_code), 32'h5);
    check("k5_held", 32'(key_held), 32'h1);
    goto(240); check("k5_one_cycle", 32'(key_valid), 32'h0);
    goto(287); check("k5_no_repeat", 32'(pulse_cnt), 32'd1);
    pressed = '0;

    // Release: key_held drops after the third NONE frame, code retained.
    goto(334); check("rel_held_before", 32'(key_held), 32'h1);
    goto(335);
    check("rel_held_after", 32'(key_held), 32'h0);
    check("rel_code_kept", 32'(key_code), 32'h5);
    pressed = kb(1); exp_q.push_back(0);
    goto(383);
    check("k0_valid", 32'(key_valid), 32'h1);
    check("k0_code", 32'(key_code), 32'h0);
    // Direct change 0 -> 3 with no release in between.
    pressed = kb(5); exp_q.push_back(3);
    goto(431);
    check("k3_valid", 32'(key_valid), 32'h1);
    check("k3_code", 32'(key_code), 32'h3);
    pressed = '0;
    goto(479); check("k3_released", 32'(key_held), 32'h0);

    // Keys 1 and 9 together.
    pressed = kb(3) | kb(11);
    goto(526); check("multi_before", 32'(multi_key), 32'h0);
    goto(527);
    check("multi_set", 32'(multi_key), 32'h1);
    check("multi_held", 32'(key_held), 32'h0);
    check("multi_code_kept", 32'(key_code), 32'h3);
    goto(543); check("multi_no_valid", 32'(pulse_cnt), 32'd3);
    pressed = '0;
    goto(591); check("multi_cleared", 32'(multi_key), 32'h0);

    // Key 7 pressed, then reset mid-debounce: the count must restart.
    pressed = kb(9); exp_q.push_back(7);
    goto(629);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_code", 32'(key_code), 32'h0);
    check("mid_rst_row", 32'(row), 32'h1);
    check("mid_rst_held", 32'(key_held), 32'h0);
    rst = 1'b0;
    goto(15); check("k7_no_early1", 32'(key_valid), 32'h0);
    goto(31); check("k7_no_early2", 32'(key_held), 32'h0);
    goto(46); check("k7_before", 32'(key_valid), 32'h0);
    goto(47);
    check("k7_valid", 32'(key_valid), 32'h1);
    check("k7_code", 32'(key_code), 32'h7);
    check("k7_held", 32'(key_held), 32'h1);
    goto(60);
    check("total_pulses", 32'(pulse_cnt), 32'd4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
